// File: rtl/axi_defination_pkg.sv
// Shared AXI definitions for the slave-side memory controller:
// burst/response encodings and the controller state type.
package axi_defination_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4
    } ctrl_state_t;

    // Side that was served most recently; the other side wins the next tie.
    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

endpackage

// File: rtl/axi_slave_mem_ctrl_if.sv
// AXI4 slave port bundle (AW/W/B/AR/R) for axi_slave_mem_ctrl.
// Ports: all five channels; modport slave = controller side, master = requester side.
// Handshake: a transfer happens on a rising clock edge where VALID and READY are
// both high; VALID and its payload stay stable until that edge, READY may change
// freely.
interface axi_slave_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              AWVALID, AWREADY;
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;

    logic                WVALID, WREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;

    logic            BVALID, BREADY;
    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;

    logic              ARVALID, ARREADY;
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;

    logic              RVALID, RREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;

    modport slave (
        input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        output AWREADY,
        input  WVALID, WDATA, WSTRB, WLAST,
        output WREADY,
        output BVALID, BID, BRESP,
        input  BREADY,
        input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        output ARREADY,
        output RVALID, RID, RDATA, RRESP, RLAST,
        input  RREADY
    );

    modport master (
        output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        input  AWREADY,
        output WVALID, WDATA, WSTRB, WLAST,
        input  WREADY,
        input  BVALID, BID, BRESP,
        output BREADY,
        output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        input  ARREADY,
        input  RVALID, RID, RDATA, RRESP, RLAST,
        output RREADY
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational burst address generator.
// Inputs : current byte address, LEN, SIZE, BURST of the active burst.
// Outputs: next beat byte address, memory word address of the current beat,
//          burst-level errors (size, burst type, wrap length) and the
//          beat-level out-of-range error.
module axi_burst_addr_gen
    import axi_defination_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 10
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic [MEM_AW-1:0] word_addr,
    output logic              size_err,
    output logic              burst_type_err,
    output logic              wrap_len_err,
    output logic              beat_err
);
    localparam int BYTE_BITS = $clog2(DATA_W / 8);
    localparam int WORD_TOP  = MEM_AW + BYTE_BITS;  // first byte-address bit above the memory

    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        inc       = ADDR_W'(1) << size;
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);

        size_err       = (size > 3'(BYTE_BITS));
        burst_type_err = (burst == 2'b11);
        wrap_len_err   = (burst == BURST_WRAP) &&
                         !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));

        word_addr = addr[WORD_TOP-1:BYTE_BITS];
        beat_err  = |addr[ADDR_W-1:WORD_TOP];

        case (burst)
            // Aligning first makes an unaligned start land on the next boundary.
            BURST_INCR: next_addr = (addr & ~(inc - ADDR_W'(1))) + inc;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + inc) & wrap_mask);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_mem_ctrl.sv
// AXI4 slave controller serialising one write or read burst at a time onto a
// single-port memory.
// Ports: ACLK/ARESET (async, active high), axi (slave modport of the AXI bundle),
//        mem_en/mem_we/mem_addr/mem_wdata/mem_wstrb to the memory, mem_rdata
//        from it (valid one cycle after a read strobe), dbg_state = FSM state.
module axi_slave_mem_ctrl
    import axi_defination_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int MEM_AW = 10
) (
    input  logic                ACLK,
    input  logic                ARESET,
    axi_slave_mem_ctrl_if.slave axi,
    output logic                mem_en,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output ctrl_state_t         dbg_state
);
    ctrl_state_t state, state_nxt;
    grant_t      last_grant, last_grant_nxt;

    logic [ID_W-1:0]   id_q, id_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [7:0]        len_q, len_nxt;
    logic [2:0]        size_q, size_nxt;
    logic [1:0]        burst_q, burst_nxt;
    logic [7:0]        beat_q, beat_nxt;
    logic              err_q, err_nxt;

    logic [ADDR_W-1:0] next_addr;
    logic [MEM_AW-1:0] word_addr;
    logic              size_err, burst_type_err, wrap_len_err, beat_err;
    logic              burst_err, access_ok, last_beat, grant_wr, grant_rd;

    axi_burst_addr_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)
    ) u_addr_gen (
        .addr           (addr_q),
        .len            (len_q),
        .size           (size_q),
        .burst          (burst_q),
        .next_addr      (next_addr),
        .word_addr      (word_addr),
        .size_err       (size_err),
        .burst_type_err (burst_type_err),
        .wrap_len_err   (wrap_len_err),
        .beat_err       (beat_err)
    );

    assign dbg_state = state;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            last_grant <= GRANT_READ;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            id_q       <= id_nxt;
            addr_q     <= addr_nxt;
            len_q      <= len_nxt;
            size_q     <= size_nxt;
            burst_q    <= burst_nxt;
            beat_q     <= beat_nxt;
            err_q      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        id_nxt         = id_q;
        addr_nxt       = addr_q;
        len_nxt        = len_q;
        size_nxt       = size_q;
        burst_nxt      = burst_q;
        beat_nxt       = beat_q;
        err_nxt        = err_q;

        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BID     = '0;
        axi.BRESP   = RESP_OKAY;
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RID     = '0;
        axi.RDATA   = '0;
        axi.RRESP   = RESP_OKAY;
        axi.RLAST   = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;

        burst_err = size_err || burst_type_err || wrap_len_err;
        access_ok = !burst_err && !beat_err;
        last_beat = (beat_q == len_q);
        // A tie goes to the side that was not served last.
        grant_wr  = axi.AWVALID && (!axi.ARVALID || (last_grant == GRANT_READ));
        grant_rd  = axi.ARVALID && !grant_wr;

        case (state)
            IDLE: begin
                // READYs are gated so they read low while reset is held.
                if (!ARESET && grant_wr) begin
                    axi.AWREADY = 1'b1;
                    id_nxt    = axi.AWID;
                    addr_nxt  = axi.AWADDR;
                    len_nxt   = axi.AWLEN;
                    size_nxt  = axi.AWSIZE;
                    burst_nxt = axi.AWBURST;
                    beat_nxt  = '0;
                    err_nxt   = 1'b0;
                    state_nxt = WR_DATA;
                end else if (!ARESET && grant_rd) begin
                    axi.ARREADY = 1'b1;
                    id_nxt    = axi.ARID;
                    addr_nxt  = axi.ARADDR;
                    len_nxt   = axi.ARLEN;
                    size_nxt  = axi.ARSIZE;
                    burst_nxt = axi.ARBURST;
                    beat_nxt  = '0;
                    err_nxt   = 1'b0;
                    state_nxt = RD_REQ;
                end
            end
            WR_DATA: begin
                axi.WREADY = 1'b1;
                if (axi.WVALID) begin
                    if (access_ok) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = word_addr;
                        mem_wdata = axi.WDATA;
                        mem_wstrb = axi.WSTRB;
                    end
                    addr_nxt = next_addr;
                    beat_nxt = beat_q + 8'd1;
                    // The beat count, not WLAST, ends the burst; a disagreement is reported.
                    err_nxt  = err_q || beat_err || (axi.WLAST != last_beat);
                    if (last_beat) state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                axi.BVALID = 1'b1;
                axi.BID    = id_q;
                axi.BRESP  = (err_q || burst_err) ? RESP_SLVERR : RESP_OKAY;
                if (axi.BREADY) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = GRANT_WRITE;
                end
            end
            RD_REQ: begin
                if (access_ok) begin
                    mem_en   = 1'b1;
                    mem_addr = word_addr;
                end
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                // addr_q only moves on acceptance, so RRESP/RDATA hold while stalled.
                axi.RVALID = 1'b1;
                axi.RID    = id_q;
                axi.RLAST  = last_beat;
                axi.RDATA  = access_ok ? mem_rdata : '0;
                axi.RRESP  = access_ok ? RESP_OKAY : RESP_SLVERR;
                if (axi.RREADY) begin
                    if (last_beat) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = GRANT_READ;
                    end else begin
                        addr_nxt  = next_addr;
                        beat_nxt  = beat_q + 8'd1;
                        state_nxt = RD_REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_slave_mem_ctrl.sv
// Directed bench for axi_slave_mem_ctrl with a behavioural single-port memory.
module tb_axi_slave_mem_ctrl;
    import axi_defination_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int MEM_AW = 10;

    // clock / reset
    logic ACLK;
    logic ARESET;
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_slave_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

    logic                mem_en, mem_we;
    logic [MEM_AW-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [DATA_W-1:0]   mem_rdata;
    ctrl_state_t         dbg_state;

    axi_slave_mem_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_AW(MEM_AW)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .axi       (axi.slave),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // memory model and access logs
    logic [DATA_W-1:0]        mem [0:(1<<MEM_AW)-1];
    logic [MEM_AW+DATA_W-1:0] act_q[$];
    logic [MEM_AW+DATA_W-1:0] exp_q[$];
    logic [MEM_AW-1:0]        rd_log[$];

    always @(posedge ACLK) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < DATA_W/8; b++)
                    if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                act_q.push_back({mem_addr, mem_wdata});
            end else begin
                mem_rdata <= mem[mem_addr];
                rd_log.push_back(mem_addr);
            end
        end
    end

    // scoreboard
    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] wdat      [16];
    logic [DATA_W-1:0] rexp      [16];
    logic [1:0]        rresp_exp [16];
    logic [MEM_AW-1:0] raddr_exp [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_wr(input logic [MEM_AW-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endfunction

    task automatic sb_compare();
        check("wr_count", 64'(act_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0)
            check("wr_beat", 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
    endtask

    // driver tasks
    task automatic write_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int last_idx,
                               input logic [1:0] exp_resp, input int bdelay, input bit tie);
        int n;
        act_q.delete();
        @(negedge ACLK);
        axi.AWVALID = 1'b1; axi.AWID = id; axi.AWADDR = addr;
        axi.AWLEN = len; axi.AWSIZE = size; axi.AWBURST = burst;
        if (tie) axi.ARVALID = 1'b1;
        #1;
        n = 0;
        while (!axi.AWREADY && n < 20) begin @(negedge ACLK); #1; n++; end
        check("aw_ready", 64'(axi.AWREADY), 64'd1);
        check("ar_ready_blocked", 64'(axi.ARREADY), 64'd0);
        @(negedge ACLK);
        axi.AWVALID = 1'b0;
        if (tie) axi.ARVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi.WVALID = 1'b1; axi.WDATA = wdat[i]; axi.WSTRB = '1;
            axi.WLAST = (i == last_idx);
            #1 check("w_ready", 64'(axi.WREADY), 64'd1);
            @(negedge ACLK);
        end
        axi.WVALID = 1'b0; axi.WLAST = 1'b0;
        #1;
        for (int i = 0; i <= bdelay; i++) begin
            check("b_valid", 64'(axi.BVALID), 64'd1);
            check("b_id", 64'(axi.BID), 64'(id));
            check("b_resp", 64'(axi.BRESP), 64'(exp_resp));
            if (i < bdelay) begin @(negedge ACLK); #1; end
        end
        axi.BREADY = 1'b1;
        @(negedge ACLK);
        axi.BREADY = 1'b0;
        #1 check("b_done", 64'(axi.BVALID), 64'd0);
        sb_compare();
    endtask

    task automatic read_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input int stall_idx,
                              input int n_rd, input bit tie);
        int n;
        logic [DATA_W-1:0] held;
        rd_log.delete();
        @(negedge ACLK);
        axi.ARVALID = 1'b1; axi.ARID = id; axi.ARADDR = addr;
        axi.ARLEN = len; axi.ARSIZE = size; axi.ARBURST = burst;
        if (tie) axi.AWVALID = 1'b1;
        #1;
        n = 0;
        while (!axi.ARREADY && n < 20) begin @(negedge ACLK); #1; n++; end
        check("ar_ready", 64'(axi.ARREADY), 64'd1);
        check("aw_ready_blocked", 64'(axi.AWREADY), 64'd0);
        @(negedge ACLK);
        axi.ARVALID = 1'b0;
        if (tie) axi.AWVALID = 1'b0;
        #1 check("r_first_gap", 64'(axi.RVALID), 64'd0);
        @(negedge ACLK);
        for (int i = 0; i <= int'(len); i++) begin
            #1;
            check("r_valid", 64'(axi.RVALID), 64'd1);
            check("r_data", 64'(axi.RDATA), 64'(rexp[i]));
            check("r_resp", 64'(axi.RRESP), 64'(rresp_exp[i]));
            check("r_last", 64'(axi.RLAST), 64'(i == int'(len)));
            check("r_id", 64'(axi.RID), 64'(id));
            if (i == stall_idx) begin
                held = rexp[i];
                repeat (2) begin
                    @(negedge ACLK); #1;
                    check("r_hold_valid", 64'(axi.RVALID), 64'd1);
                    check("r_hold_data", 64'(axi.RDATA), 64'(held));
                end
            end
            axi.RREADY = 1'b1;
            @(negedge ACLK);
            axi.RREADY = 1'b0;
            #1 check("r_gap", 64'(axi.RVALID), 64'd0);
            @(negedge ACLK);
        end
        check("rd_count", 64'(rd_log.size()), 64'(n_rd));
        for (int k = 0; k < n_rd && rd_log.size() > 0; k++)
            check("rd_addr", 64'(rd_log.pop_front()), 64'(raddr_exp[k]));
    endtask

    // watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // directed sequence
    initial begin
        ARESET = 1'b1;
        axi.AWVALID = 0; axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0;
        axi.WVALID = 0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 0;
        axi.BREADY = 0;
        axi.ARVALID = 0; axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0; axi.ARBURST = '0;
        axi.RREADY = 0;

        // reset values, with both VALIDs high during reset
        repeat (2) @(negedge ACLK);
        axi.AWVALID = 1'b1; axi.ARVALID = 1'b1;
        #1;
        check("rst_awready", 64'(axi.AWREADY), 64'd0);
        check("rst_arready", 64'(axi.ARREADY), 64'd0);
        check("rst_bvalid", 64'(axi.BVALID), 64'd0);
        check("rst_rvalid", 64'(axi.RVALID), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        axi.AWVALID = 1'b0; axi.ARVALID = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;

        // ties: write, read, write, read (single beats)
        wdat[0] = 32'hA5A5_0001; exp_wr(10'd16, 32'hA5A5_0001);
        write_burst(4'd1, 32'h40, 8'd0, 3'd2, BURST_INCR, 0, RESP_OKAY, 0, 1'b1);
        rexp[0] = 32'hA5A5_0001; rresp_exp[0] = RESP_OKAY; raddr_exp[0] = 10'd16;
        read_burst(4'd2, 32'h40, 8'd0, 3'd2, BURST_INCR, -1, 1, 1'b1);
        wdat[0] = 32'h0000_BEEF; exp_wr(10'd17, 32'h0000_BEEF);
        write_burst(4'd3, 32'h44, 8'd0, 3'd2, BURST_INCR, 0, RESP_OKAY, 0, 1'b1);
        rexp[0] = 32'h0000_BEEF; raddr_exp[0] = 10'd17;
        read_burst(4'd4, 32'h44, 8'd0, 3'd2, BURST_INCR, -1, 1, 1'b1);

        // INCR write 0x10, 4 beats, B held for two cycles
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'(i + 1);
            exp_wr(10'(4 + i), 32'(i + 1));
        end
        write_burst(4'd5, 32'h10, 8'd3, 3'd2, BURST_INCR, 3, RESP_OKAY, 2, 1'b0);

        // INCR read-back with a stall on beat 2
        for (int i = 0; i < 4; i++) begin
            rexp[i] = 32'(i + 1); rresp_exp[i] = RESP_OKAY; raddr_exp[i] = 10'(4 + i);
        end
        read_burst(4'd6, 32'h10, 8'd3, 3'd2, BURST_INCR, 1, 4, 1'b0);

        // WRAP read from 0x18: words 6,7,4,5
        rexp[0] = 32'd3; rexp[1] = 32'd4; rexp[2] = 32'd1; rexp[3] = 32'd2;
        raddr_exp[0] = 10'd6; raddr_exp[1] = 10'd7; raddr_exp[2] = 10'd4; raddr_exp[3] = 10'd5;
        read_burst(4'd7, 32'h18, 8'd3, 3'd2, BURST_WRAP, -1, 4, 1'b0);

        // oversize read: every beat SLVERR with zero data, no memory access
        for (int i = 0; i < 4; i++) begin
            rexp[i] = '0; rresp_exp[i] = RESP_SLVERR;
        end
        read_burst(4'd8, 32'h10, 8'd3, 3'd3, BURST_INCR, -1, 0, 1'b0);

        // write crossing the end of memory: only word 1023 is written
        wdat[0] = 32'h11; wdat[1] = 32'h22;
        exp_wr(10'd1023, 32'h11);
        write_burst(4'd9, 32'hFFC, 8'd1, 3'd2, BURST_INCR, 1, RESP_SLVERR, 0, 1'b0);

        // early WLAST on beat 2 of 4: data still written, SLVERR
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'hC0 + 32'(i);
            exp_wr(10'(32 + i), 32'hC0 + 32'(i));
        end
        write_burst(4'd10, 32'h80, 8'd3, 3'd2, BURST_INCR, 1, RESP_SLVERR, 0, 1'b0);

        // reset during beat 2 of an 8-beat write
        act_q.delete();
        @(negedge ACLK);
        axi.AWVALID = 1'b1; axi.AWID = 4'd11; axi.AWADDR = 32'h100;
        axi.AWLEN = 8'd7; axi.AWSIZE = 3'd2; axi.AWBURST = BURST_INCR;
        #1 check("rst_burst_aw_ready", 64'(axi.AWREADY), 64'd1);
        @(negedge ACLK);
        axi.AWVALID = 1'b0;
        axi.WVALID = 1'b1; axi.WDATA = 32'h7000_0001; axi.WSTRB = '1; axi.WLAST = 1'b0;
        @(negedge ACLK);
        axi.WDATA = 32'h7000_0002;
        ARESET = 1'b1;
        #1;
        check("mid_rst_wready", 64'(axi.WREADY), 64'd0);
        check("mid_rst_mem_en", 64'(mem_en), 64'd0);
        check("mid_rst_mem_we", 64'(mem_we), 64'd0);
        check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("mid_rst_bvalid", 64'(axi.BVALID), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        @(negedge ACLK);
        axi.WVALID = 1'b0;
        ARESET = 1'b0;
        repeat (3) begin
            @(negedge ACLK); #1;
            check("no_b_after_rst", 64'(axi.BVALID), 64'd0);
        end
        exp_wr(10'd64, 32'h7000_0001);
        sb_compare();

        // next write after reset is accepted normally
        wdat[0] = 32'h7000_00FF; exp_wr(10'd65, 32'h7000_00FF);
        write_burst(4'd12, 32'h104, 8'd0, 3'd2, BURST_INCR, 0, RESP_OKAY, 0, 1'b0);
        rexp[0] = 32'h7000_0001; rexp[1] = 32'h7000_00FF;
        rresp_exp[0] = RESP_OKAY; rresp_exp[1] = RESP_OKAY;
        raddr_exp[0] = 10'd64; raddr_exp[1] = 10'd65;
        read_burst(4'd13, 32'h100, 8'd1, 3'd2, BURST_INCR, -1, 2, 1'b0);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
